// File: rtl/queue_op_pkg.sv
// rtl/queue_op_pkg.sv - opcode, status and FSM encodings shared by the queue op front-end
package queue_op_pkg;

  // Request / response opcodes
  localparam logic [2:0] OP_ENQ_BACK  = 3'd0;
  localparam logic [2:0] OP_ENQ_FRONT = 3'd1;
  localparam logic [2:0] OP_DEQ_FRONT = 3'd2;
  localparam logic [2:0] OP_DEQ_BACK  = 3'd3;
  localparam logic [2:0] OP_UPD       = 3'd4;
  localparam logic [2:0] OP_DEL       = 3'd5;

  // Response status codes
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_REJECT  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/queue_op_frontend.sv
// rtl/queue_op_frontend.sv - one-at-a-time request front-end for the v3a queue controller
//
// Accepts a val/rdy request (op, tag, data), drives exactly one controller
// enable until its completion or a timeout, and returns one val/rdy response.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    request channel (val/rdy, op, tag, data)
//   resp_*                   response channel (val/rdy, op, status, tag, data)
//   *_en / *_cpl             per-operation controller enable / completion
//   enq_*_data, upd_data_in  captured request payload
//   upd_tag_in, del_tag_in   captured request tag
//   enq_*_tag_out            tags allocated by the controller
//   deq_*_data               payloads returned by the controller
//   count                    mirror of the controller occupancy
module queue_op_frontend
  import queue_op_pkg::*;
#(
  parameter int p_depth     = 32,
  parameter int p_ptrwidth  = $clog2(p_depth),
  parameter int p_chanwidth = 32,
  parameter int p_timeout   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [2:0]             req_op,
  input  logic [p_ptrwidth-1:0]  req_tag,
  input  logic [p_chanwidth-1:0] req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [2:0]             resp_op,
  output logic [1:0]             resp_status,
  output logic [p_ptrwidth-1:0]  resp_tag,
  output logic [p_chanwidth-1:0] resp_data,
  output logic                   enq_back_en,
  output logic                   enq_front_en,
  output logic                   deq_front_en,
  output logic                   deq_back_en,
  output logic                   upd_en,
  output logic                   del_en,
  input  logic                   enq_back_cpl,
  input  logic                   enq_front_cpl,
  input  logic                   deq_front_cpl,
  input  logic                   deq_back_cpl,
  input  logic                   upd_cpl,
  input  logic                   del_cpl,
  output logic [p_chanwidth-1:0] enq_back_data,
  output logic [p_chanwidth-1:0] enq_front_data,
  output logic [p_chanwidth-1:0] upd_data_in,
  output logic [p_ptrwidth-1:0]  upd_tag_in,
  output logic [p_ptrwidth-1:0]  del_tag_in,
  input  logic [p_ptrwidth-1:0]  enq_back_tag_out,
  input  logic [p_ptrwidth-1:0]  enq_front_tag_out,
  input  logic [p_chanwidth-1:0] deq_front_data,
  input  logic [p_chanwidth-1:0] deq_back_data,
  output logic [p_ptrwidth:0]    count
);

  localparam int CW = p_ptrwidth + 1;
  localparam int TW = $clog2(p_timeout);
  localparam logic [CW-1:0] DEPTH_C = CW'(p_depth);
  localparam logic [TW-1:0] TLAST   = TW'(p_timeout - 1);

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [p_ptrwidth-1:0]  tag_q, tag_d;
  logic [p_chanwidth-1:0] data_q, data_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          count_q, count_d;
  logic [2:0]             resp_op_q, resp_op_d;
  logic [1:0]             resp_status_q, resp_status_d;
  logic [p_ptrwidth-1:0]  resp_tag_q, resp_tag_d;
  logic [p_chanwidth-1:0] resp_data_q, resp_data_d;

  // Bit i of these vectors belongs to opcode i.
  logic [5:0] cpl_vec, sel_vec, en_vec;
  logic       match_cpl;
  logic       req_is_enq;

  assign cpl_vec = {del_cpl, upd_cpl, deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl};
  assign sel_vec = 6'(1) << op_q;
  // en falls combinationally in the cpl cycle so the controller never sees a second fire.
  assign en_vec  = (state_q == S_ISSUE) ? (sel_vec & ~cpl_vec) : 6'b0;
  assign match_cpl = |(sel_vec & cpl_vec);
  assign {del_en, upd_en, deq_back_en, deq_front_en, enq_front_en, enq_back_en} = en_vec;

  assign req_is_enq = (req_op == OP_ENQ_BACK) || (req_op == OP_ENQ_FRONT);

  assign req_rdy        = (state_q == S_IDLE) && !rst;
  assign resp_val       = (state_q == S_RESP);
  assign resp_op        = resp_op_q;
  assign resp_status    = resp_status_q;
  assign resp_tag       = resp_tag_q;
  assign resp_data      = resp_data_q;
  assign enq_back_data  = data_q;
  assign enq_front_data = data_q;
  assign upd_data_in    = data_q;
  assign upd_tag_in     = tag_q;
  assign del_tag_in     = tag_q;
  assign count          = count_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    tag_d         = tag_q;
    data_d        = data_q;
    timer_d       = timer_q;
    count_d       = count_q;
    resp_op_d     = resp_op_q;
    resp_status_d = resp_status_q;
    resp_tag_d    = resp_tag_q;
    resp_data_d   = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          op_d        = req_op;
          tag_d       = req_tag;
          data_d      = req_data;
          timer_d     = '0;
          resp_op_d   = req_op;
          resp_data_d = '0;
          // UPD/DEL echo their tag whatever the outcome; ENQ tags come from the controller.
          resp_tag_d    = (req_op == OP_UPD || req_op == OP_DEL) ? req_tag : '0;
          resp_status_d = ST_OK;
          if (req_op > OP_DEL) begin
            resp_status_d = ST_ILLEGAL;
            state_d       = S_RESP;
          end else if (req_is_enq ? (count_q == DEPTH_C) : (count_q == '0)) begin
            resp_status_d = ST_REJECT;
            state_d       = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A completion arriving on the last timer cycle still counts as OK.
        if (match_cpl) begin
          state_d       = S_RESP;
          resp_status_d = ST_OK;
          case (op_q)
            OP_ENQ_BACK: begin
              resp_tag_d = enq_back_tag_out;
              if (count_q != DEPTH_C) count_d = count_q + 1'b1;
            end
            OP_ENQ_FRONT: begin
              resp_tag_d = enq_front_tag_out;
              if (count_q != DEPTH_C) count_d = count_q + 1'b1;
            end
            OP_DEQ_FRONT: begin
              resp_data_d = deq_front_data;
              if (count_q != '0) count_d = count_q - 1'b1;
            end
            OP_DEQ_BACK: begin
              resp_data_d = deq_back_data;
              if (count_q != '0) count_d = count_q - 1'b1;
            end
            OP_DEL: begin
              if (count_q != '0) count_d = count_q - 1'b1;
            end
            default: ;
          endcase
        end else if (timer_q == TLAST) begin
          state_d       = S_RESP;
          resp_status_d = ST_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      tag_q         <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      count_q       <= '0;
      resp_op_q     <= '0;
      resp_status_q <= '0;
      resp_tag_q    <= '0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      resp_op_q     <= resp_op_d;
      resp_status_q <= resp_status_d;
      resp_tag_q    <= resp_tag_d;
      resp_data_q   <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_queue_op_frontend.sv
// tb/tb_queue_op_frontend.sv - randomized self-checking bench for queue_op_frontend
module tb_queue_op_frontend;
  import queue_op_pkg::*;

  localparam int DEPTH = 32;
  localparam int PW    = 5;
  localparam int DW    = 32;
  localparam int TO    = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_val, req_rdy, resp_val, resp_rdy;
  logic [2:0]    req_op, resp_op;
  logic [PW-1:0] req_tag, resp_tag;
  logic [DW-1:0] req_data, resp_data;
  logic [1:0]    resp_status;
  logic enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en;
  logic enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl, del_cpl;
  logic [DW-1:0] enq_back_data, enq_front_data, upd_data_in;
  logic [PW-1:0] upd_tag_in, del_tag_in;
  logic [PW-1:0] enq_back_tag_out, enq_front_tag_out;
  logic [DW-1:0] deq_front_data, deq_back_data;
  logic [PW:0]   count;

  queue_op_frontend #(.p_depth(DEPTH), .p_chanwidth(DW), .p_timeout(TO)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_tag(req_tag), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_status(resp_status),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .enq_back_en(enq_back_en), .enq_front_en(enq_front_en), .deq_front_en(deq_front_en),
    .deq_back_en(deq_back_en), .upd_en(upd_en), .del_en(del_en),
    .enq_back_cpl(enq_back_cpl), .enq_front_cpl(enq_front_cpl), .deq_front_cpl(deq_front_cpl),
    .deq_back_cpl(deq_back_cpl), .upd_cpl(upd_cpl), .del_cpl(del_cpl),
    .enq_back_data(enq_back_data), .enq_front_data(enq_front_data), .upd_data_in(upd_data_in),
    .upd_tag_in(upd_tag_in), .del_tag_in(del_tag_in),
    .enq_back_tag_out(enq_back_tag_out), .enq_front_tag_out(enq_front_tag_out),
    .deq_front_data(deq_front_data), .deq_back_data(deq_back_data),
    .count(count)
  );

  logic [5:0] en_vec, cpl_vec, cpl_q;
  assign en_vec  = {del_en, upd_en, deq_back_en, deq_front_en, enq_front_en, enq_back_en};
  assign cpl_vec = cpl_q;
  assign {del_cpl, upd_cpl, deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl} = cpl_q;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int            m_count = 0;
  logic [DW-1:0] cap_data = '0;
  logic [PW-1:0] cap_tag = '0;
  logic [5:0]    exp_mask = '0;
  bit            chk_on = 1'b0;

  // Controller model: completes after en has been high cpl_delay cycles (0 = never),
  // plus random completions on the other five channels.
  int cpl_delay = 0;
  int en_run = 0;
  int cur_idx = 7;
  bit noise_on = 1'b0;
  logic [5:0] nxt;
  always @(posedge clk) begin
    if (rst) begin
      en_run <= 0;
      cpl_q  <= '0;
    end else begin
      nxt = '0;
      if (|en_vec) begin
        if (cpl_delay != 0 && en_run + 1 == cpl_delay) nxt = en_vec;
        en_run <= en_run + 1;
      end else begin
        en_run <= 0;
      end
      if (noise_on) nxt = nxt | (6'($urandom) & ~(6'(1) << cur_idx));
      cpl_q <= nxt;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] pack_resp();
    return {resp_op, resp_status, resp_tag, resp_data};
  endfunction

  // Per-cycle compare against the reference state
  always @(negedge clk) begin
    if (chk_on) begin
      chk("en_allowed", {58'd0, en_vec & ~exp_mask}, 64'd0);
      chk("en_vs_cpl", {58'd0, en_vec & cpl_vec}, 64'd0);
      chk("ctrl_outs", {enq_back_data ^ cap_data, enq_front_data ^ cap_data,
                        upd_tag_in ^ cap_tag}, 69'd0);
      chk("ctrl_outs2", {upd_data_in ^ cap_data, del_tag_in ^ cap_tag}, 37'd0);
      if (req_rdy) chk("count", count, m_count);
    end
  end

  logic [1:0]    g_st;
  logic [PW-1:0] g_tag;
  logic [DW-1:0] g_data;
  int            g_en, g_lat;

  task automatic do_req(input logic [2:0] op, input logic [PW-1:0] tag, input logic [DW-1:0] data,
                        input int delay, input int hold,
                        input logic [PW-1:0] ctag, input logic [DW-1:0] cdata);
    bit legal, is_enq, rej, issue, ok;
    logic [1:0] e_st;
    logic [PW-1:0] e_tag;
    logic [DW-1:0] e_data;
    int e_lat, e_en;
    logic [41:0] first;
    legal  = (op <= 3'd5);
    is_enq = (op <= 3'd1);
    rej    = legal && (is_enq ? (m_count == DEPTH) : (m_count == 0));
    issue  = legal && !rej;
    ok     = issue && delay >= 1 && delay <= TO - 1;
    e_st   = !legal ? ST_ILLEGAL : rej ? ST_REJECT : ok ? ST_OK : ST_TIMEOUT;
    e_lat  = !issue ? 1 : ok ? delay + 2 : TO + 1;
    e_en   = !issue ? 0 : ok ? delay : TO;
    e_tag  = (op == 3'd4 || op == 3'd5) ? tag : (ok && is_enq) ? ctag : '0;
    e_data = (ok && (op == 3'd2 || op == 3'd3)) ? cdata : '0;

    @(negedge clk);
    cpl_delay = delay;
    cur_idx = int'(op);
    enq_back_tag_out  = (op == 3'd0) ? ctag : ctag + 5'd1;
    enq_front_tag_out = (op == 3'd1) ? ctag : ctag + 5'd2;
    deq_front_data    = (op == 3'd2) ? cdata : ~cdata;
    deq_back_data     = (op == 3'd3) ? cdata : cdata ^ 32'h5a5a_5a5a;
    req_val = 1'b1; req_op = op; req_tag = tag; req_data = data;
    chk("req_rdy_idle", req_rdy, 1);
    @(posedge clk);
    cap_data = data; cap_tag = tag;
    exp_mask = issue ? (6'(1) << op) : 6'd0;
    @(negedge clk);
    req_val = 1'b0;
    g_lat = 1; g_en = 0;
    while (!resp_val && g_lat < 300) begin
      if (|en_vec) g_en++;
      @(negedge clk);
      g_lat++;
    end
    exp_mask = '0;
    chk("latency", g_lat, e_lat);
    chk("en_cycles", g_en, e_en);
    chk("resp_fields", pack_resp(), {op, e_st, e_tag, e_data});
    g_st = resp_status; g_tag = resp_tag; g_data = resp_data;
    if (e_st == ST_OK) begin
      if (is_enq && m_count < DEPTH) m_count++;
      if ((op == 3'd2 || op == 3'd3 || op == 3'd5) && m_count > 0) m_count--;
    end
    first = pack_resp();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("resp_hold", pack_resp(), first);
      chk("hold_val_rdy", {resp_val, req_rdy}, 2'b10);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("after_resp", {resp_val, req_rdy}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    int r, dly;
    rst = 1'b1; req_val = 1'b0; resp_rdy = 1'b0;
    req_op = '0; req_tag = '0; req_data = '0;
    enq_back_tag_out = '0; enq_front_tag_out = '0; deq_front_data = '0; deq_back_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_en", en_vec, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_resp", pack_resp(), 0);
    chk("rst_count", count, 0);
    chk("rst_ctrl", |{enq_back_data, enq_front_data, upd_data_in, upd_tag_in, del_tag_in}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_rdy", req_rdy, 1);
    chk_on = 1'b1; noise_on = 1'b1;

    // Empty queue: DEQ rejected, then illegal opcodes
    do_req(OP_DEQ_FRONT, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0);
    chk("deq_empty_status", g_st, ST_REJECT);
    do_req(3'd7, 5'd9, 32'h1, 1, 0, 5'd0, 32'h0);
    chk("op7_status", g_st, ST_ILLEGAL);
    do_req(3'd6, 5'd9, 32'h1, 1, 0, 5'd0, 32'h0);

    // First enqueue
    do_req(OP_ENQ_BACK, 5'd0, 32'hA5, 1, 0, 5'd3, 32'h0);
    chk("enq_tag_lit", g_tag, 3);
    chk("enq_en_lit", g_en, 1);
    chk("enq_lat_lit", g_lat, 3);
    chk("count_1_lit", count, 1);

    // Fill, reject at full, then DEQ_BACK
    while (m_count < DEPTH)
      do_req(3'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom_range(1, 4), 0,
             5'($urandom), $urandom);
    chk("count_full_lit", count, 32);
    do_req(OP_ENQ_FRONT, 5'd0, 32'h1, 1, 0, 5'd1, 32'h0);
    chk("enq_full_status", g_st, ST_REJECT);
    do_req(OP_DEQ_BACK, 5'd0, 32'h0, 2, 0, 5'd0, 32'h1234);
    chk("deq_data_lit", g_data, 32'h1234);
    chk("count_31_lit", count, 31);

    // Slow UPD, DEL timeouts around the boundary, held response
    do_req(OP_UPD, 5'd5, 32'h77, 10, 0, 5'd0, 32'h0);
    chk("upd_en_lit", g_en, 10);
    chk("upd_tag_lit", g_tag, 5);
    do_req(OP_DEL, 5'd2, 32'h0, 0, 0, 5'd0, 32'h0);
    chk("del_to_en_lit", g_en, 64);
    chk("del_to_status", g_st, ST_TIMEOUT);
    chk("del_to_count", count, 31);
    do_req(OP_DEL, 5'd2, 32'h0, 63, 0, 5'd0, 32'h0);
    chk("del_63_status", g_st, ST_OK);
    do_req(OP_DEL, 5'd2, 32'h0, 64, 0, 5'd0, 32'h0);
    chk("del_64_status", g_st, ST_TIMEOUT);
    do_req(OP_DEQ_FRONT, 5'd0, 32'h0, 3, 5, 5'd0, 32'hBEEF);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      op = (r == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      r = $urandom_range(0, 19);
      dly = (r == 0) ? 0 : (r == 1) ? 63 : (r == 2) ? 64 : $urandom_range(1, 6);
      do_req(op, 5'($urandom), $urandom, dly, $urandom_range(0, 3), 5'($urandom), $urandom);
    end

    // Reset during ISSUE
    if (m_count == DEPTH) do_req(OP_DEQ_FRONT, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0);
    @(negedge clk);
    cpl_delay = 0; cur_idx = 0;
    req_val = 1'b1; req_op = OP_ENQ_BACK; req_tag = 5'd0; req_data = 32'hDEAD;
    @(posedge clk);
    cap_data = 32'hDEAD; cap_tag = 5'd0; exp_mask = 6'b000001;
    @(negedge clk);
    req_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_issue_en", enq_back_en, 1);
    chk_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_issue_en", en_vec, 0);
    chk("rst_issue_resp_val", resp_val, 0);
    chk("rst_issue_req_rdy", req_rdy, 0);
    chk("rst_issue_count", count, 0);
    rst = 1'b0;
    m_count = 0; cap_data = '0; cap_tag = '0; exp_mask = '0;
    @(negedge clk);
    chk_on = 1'b1;
    do_req(OP_DEQ_BACK, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0);
    chk("post_rst_reject", g_st, ST_REJECT);
    do_req(OP_ENQ_FRONT, 5'd0, 32'h42, 2, 0, 5'd17, 32'h0);
    chk("post_rst_tag", g_tag, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
